// File: rtl/cnn_acc_pkg.sv
// cnn_acc_pkg: shared widths, accumulator state type and helpers for the conv accumulate path
// Ports: none (package) -- provides DEF_IN_WIDTH, DEF_ACC_WIDTH, acc_state_t, clog2, count_at, saturate
package cnn_acc_pkg;
   localparam int DEF_IN_WIDTH  = 14;
   localparam int DEF_ACC_WIDTH = 32;
   typedef enum logic {IDLE, RUN} acc_state_t;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   // operands remaining after l pairwise levels (odd leftovers pass through)
   function automatic int count_at(input int n, input int l);
      return (n + (1 << l) - 1) >> l;
   endfunction
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction
endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one registered pairwise-add level of the signed adder tree
// Ports: clk, rst (async, active-high); valid/first/last/bias sideband in, data (N_IN x W_IN packed signed);
//        valid_q/first_q/last_q/bias_q registered sideband, sum_q (ceil(N_IN/2) x (W_IN+1) packed signed)
module adder_tree_level
   import cnn_acc_pkg::*;
#(
   parameter int N_IN  = 2,
   parameter int W_IN  = DEF_IN_WIDTH,
   parameter int B_W   = DEF_ACC_WIDTH,
   localparam int N_OUT = (N_IN + 1) / 2,
   localparam int W_OUT = W_IN + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid,
   input  logic                   first,
   input  logic                   last,
   input  logic [B_W-1:0]         bias,
   input  logic [N_IN*W_IN-1:0]   data,
   output logic                   valid_q,
   output logic                   first_q,
   output logic                   last_q,
   output logic [B_W-1:0]         bias_q,
   output logic [N_OUT*W_OUT-1:0] sum_q
);
   logic [N_OUT*W_OUT-1:0] sum;
   for (genvar k = 0; k < N_IN / 2; k++) begin : g_pair
      assign sum[k*W_OUT +: W_OUT] = W_OUT'($signed(data[2*k*W_IN +: W_IN]))
                                   + W_OUT'($signed(data[(2*k+1)*W_IN +: W_IN]));
   end
   // odd leftover is sign-extended so every slot of the next level has the same width
   if (N_IN % 2 != 0) begin : g_odd
      assign sum[(N_OUT-1)*W_OUT +: W_OUT] = W_OUT'($signed(data[(N_IN-1)*W_IN +: W_IN]));
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         bias_q  <= '0;
         sum_q   <= '0;
      end else begin
         valid_q <= valid;
         first_q <= first;
         last_q  <= last;
         bias_q  <= bias;
         sum_q   <= sum;
      end
endmodule

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined signed adder tree with multi-beat accumulator, bias, rounding shift and saturation
// Ports: clk, rst (async, active-high); in_valid/in_first/in_last beat framing; input_numbers (NUM_INPUTS x IN_WIDTH
//        packed signed); bias (ACC_WIDTH signed, taken with group start); sum_output (OUT_WIDTH signed);
//        data_valid one-cycle result pulse; sat_flag result was clamped
module adder_tree_acc
   import cnn_acc_pkg::*;
#(
   parameter int NUM_INPUTS = 27,
   parameter int IN_WIDTH   = DEF_IN_WIDTH,
   parameter int OUT_WIDTH  = 14,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int SHIFT      = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic                           in_first,
   input  logic                           in_last,
   input  logic [NUM_INPUTS*IN_WIDTH-1:0] input_numbers,
   input  logic [ACC_WIDTH-1:0]           bias,
   output logic [OUT_WIDTH-1:0]           sum_output,
   output logic                           data_valid,
   output logic                           sat_flag
);
   localparam int LEVELS    = clog2(NUM_INPUTS);
   localparam int SUM_WIDTH = IN_WIDTH + LEVELS;
   // half-LSB rounding constant; the inner guard keeps the shift amount legal when SHIFT=0
   localparam logic signed [ACC_WIDTH:0] RND =
      (ACC_WIDTH+1)'((SHIFT > 0) ? (64'sd1 <<< (SHIFT > 0 ? SHIFT - 1 : 0)) : 64'sd0);
   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int N = count_at(NUM_INPUTS, l);
      localparam int W = IN_WIDTH + l;
      logic                                          s_valid, s_first, s_last;
      logic [ACC_WIDTH-1:0]                          s_bias;
      logic [count_at(NUM_INPUTS, l + 1)*(W+1)-1:0]  s_sum;
      logic                                          v_in, f_in, e_in;
      logic [ACC_WIDTH-1:0]                          b_in;
      logic [N*W-1:0]                                d_in;
      if (l == 0) begin : g_src
         assign {v_in, f_in, e_in, b_in, d_in} = {in_valid, in_first, in_last, bias, input_numbers};
      end else begin : g_src
         assign {v_in, f_in, e_in, b_in, d_in} = {g_lvl[l-1].s_valid, g_lvl[l-1].s_first,
                                                  g_lvl[l-1].s_last, g_lvl[l-1].s_bias, g_lvl[l-1].s_sum};
      end
      adder_tree_level #(.N_IN(N), .W_IN(W), .B_W(ACC_WIDTH)) u_level (
         .clk(clk), .rst(rst), .valid(v_in), .first(f_in), .last(e_in), .bias(b_in), .data(d_in),
         .valid_q(s_valid), .first_q(s_first), .last_q(s_last), .bias_q(s_bias), .sum_q(s_sum)
      );
   end
   logic                        t_valid, t_first, t_last;
   logic [ACC_WIDTH-1:0]        t_bias;
   logic [SUM_WIDTH-1:0]        t_sum;
   logic signed [ACC_WIDTH-1:0] t_ext, acc, acc_nxt;
   acc_state_t                  state, state_nxt;
   logic                        res_valid, res_valid_nxt;
   logic signed [ACC_WIDTH:0]   rnd;
   logic signed [63:0]          wide, clamp;
   assign {t_valid, t_first, t_last, t_bias, t_sum} = {g_lvl[LEVELS-1].s_valid, g_lvl[LEVELS-1].s_first,
                                                       g_lvl[LEVELS-1].s_last, g_lvl[LEVELS-1].s_bias,
                                                       g_lvl[LEVELS-1].s_sum};
   assign t_ext = ACC_WIDTH'($signed(t_sum));
   // a group (re)starts on any beat seen in IDLE, or on a first beat mid-group
   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc;
      res_valid_nxt = 1'b0;
      if (t_valid) begin
         acc_nxt       = (state == IDLE || t_first) ? $signed(t_bias) + t_ext : acc + t_ext;
         state_nxt     = t_last ? IDLE : RUN;
         res_valid_nxt = t_last;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         res_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         res_valid <= res_valid_nxt;
      end
   // one guard bit so the rounding add cannot wrap before the shift
   assign rnd   = ($signed({acc[ACC_WIDTH-1], acc}) + RND) >>> SHIFT;
   assign wide  = 64'(rnd);
   assign clamp = saturate(wide, OUT_WIDTH);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sum_output <= '0;
         data_valid <= 1'b0;
         sat_flag   <= 1'b0;
      end else begin
         data_valid <= res_valid;
         if (res_valid) begin
            sum_output <= clamp[OUT_WIDTH-1:0];
            sat_flag   <= clamp != wide;
         end
      end
endmodule
